// File: rtl/int_sequencer.sv
// int_sequencer
//   Interrupt/reset sequencer in front of the microcode controller. It
//   synchronises the NMI and IRQ request lines, edge-detects NMI, holds the
//   core in reset after power-up and arbitrates RESET > NMI > IRQ. It tells
//   the controller to start interrupt entry (take_int) and supplies the low
//   byte of the vector that the vector-fetch microcode reads.
//   Every output comes straight from a flip-flop, so no input reaches an
//   output in the same cycle.
//
// Parameters
//   RESET_CYCLES  cycles core_rst stays high after reset is released (>=1)
//   SYNC_STAGES   depth of the synchroniser chains on nmi and irq (>=1)
//
// Ports
//   clk       in   system clock, all logic on the rising edge
//   reset     in   synchronous, active-high reset
//   nmi       in   asynchronous NMI request, acts on its rising edge
//   irq       in   asynchronous IRQ request, acts on its level
//   I         in   processor I flag, 1 masks IRQ (NMI is not maskable)
//   sync      in   core is in its opcode-decode cycle
//   vec_ack   in   core is reading the vector low byte this cycle
//   core_rst  out  reset to the core and controller
//   take_int  out  interrupt entry request to the controller
//   vec_lo    out  vector low byte: FA NMI, FC RESET, FE IRQ
//   busy      out  an entry is in progress (reset vector or service)
module int_sequencer #(
   parameter int RESET_CYCLES = 4,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       nmi,
   input  logic       irq,
   input  logic       I,
   input  logic       sync,
   input  logic       vec_ack,
   output logic       core_rst,
   output logic       take_int,
   output logic [7:0] vec_lo,
   output logic       busy
);

   localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   localparam logic [7:0] VEC_NMI   = 8'hFA;
   localparam logic [7:0] VEC_RESET = 8'hFC;
   localparam logic [7:0] VEC_IRQ   = 8'hFE;

   typedef enum logic [1:0] {
      HOLD,
      RSTVEC,
      IDLE,
      SERVICE
   } state_t;

   state_t                 state, state_next;
   logic [CNT_W-1:0]       count, count_next;
   logic [SYNC_STAGES-1:0] nmi_sync, irq_sync;
   logic                   nmi_s, irq_s, nmi_s_d;
   logic                   nmi_rise, nmi_pend, clear_pend;
   logic                   src_nmi, src_next;
   logic                   take_next;
   logic [7:0]             vec_next;

   assign nmi_s    = nmi_sync[SYNC_STAGES-1];
   assign irq_s    = irq_sync[SYNC_STAGES-1];
   assign nmi_rise = nmi_s & ~nmi_s_d;

   always_comb begin
      state_next = state;
      count_next = count;
      take_next  = 1'b0;
      vec_next   = vec_lo;
      src_next   = src_nmi;
      clear_pend = 1'b0;
      case (state)
         HOLD: begin
            if (count == '0) begin
               state_next = RSTVEC;
               vec_next   = VEC_RESET;
            end else begin
               count_next = count - 1'b1;
            end
         end
         RSTVEC: begin
            if (vec_ack) state_next = IDLE;
         end
         IDLE: begin
            // The request already on take_int is what the core acted on, so
            // entry is decided from the registered take_int, while the source
            // is picked from the pending NMI at that moment (NMI wins).
            if (sync && take_int) begin
               src_next   = nmi_pend;
               vec_next   = nmi_pend ? VEC_NMI : VEC_IRQ;
               state_next = SERVICE;
            end else begin
               take_next = nmi_pend | (irq_s & ~I);
            end
         end
         SERVICE: begin
            if (vec_ack) begin
               state_next = IDLE;
               clear_pend = src_nmi;
            end
         end
         default: state_next = HOLD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= HOLD;
         count    <= CNT_W'(RESET_CYCLES - 1);
         nmi_sync <= '0;
         irq_sync <= '0;
         nmi_s_d  <= 1'b0;
         nmi_pend <= 1'b0;
         src_nmi  <= 1'b0;
         core_rst <= 1'b1;
         take_int <= 1'b0;
         vec_lo   <= VEC_RESET;
         busy     <= 1'b0;
      end else begin
         // Shift toward the MSB; the concatenation is one bit wider than the
         // chain and the cast drops the oldest sample.
         nmi_sync <= SYNC_STAGES'({nmi_sync, nmi});
         irq_sync <= SYNC_STAGES'({irq_sync, irq});
         nmi_s_d  <= nmi_s;
         // A new edge on the same cycle as the acknowledge must not be lost.
         nmi_pend <= nmi_rise | (nmi_pend & ~clear_pend);
         state    <= state_next;
         count    <= count_next;
         src_nmi  <= src_next;
         core_rst <= (state_next == HOLD);
         take_int <= take_next;
         vec_lo   <= vec_next;
         busy     <= (state_next == RSTVEC) || (state_next == SERVICE);
      end
   end

endmodule

// File: tb/tb_int_sequencer.sv
// tb_int_sequencer
//   Bench for int_sequencer. Directed scenarios check the power-up hold,
//   IRQ entry and masking, NMI edge handling, priority and reset during
//   service; a randomized run compares every output each cycle with a
//   behavioural model built from delay lines and a phase variable.
//   Ports of the bench: none.
module tb_int_sequencer;

   localparam int RESET_CYCLES = 4;
   localparam int SYNC_STAGES  = 2;

   localparam int PH_HOLD = 0;
   localparam int PH_RVEC = 1;
   localparam int PH_IDLE = 2;
   localparam int PH_SVC  = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       nmi = 1'b0;
   logic       irq = 1'b0;
   logic       I = 1'b0;
   logic       sync = 1'b0;
   logic       vec_ack = 1'b0;
   logic       core_rst;
   logic       take_int;
   logic [7:0] vec_lo;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model
   bit   nh [0:SYNC_STAGES];
   bit   ih [0:SYNC_STAGES];
   int   m_phase;
   int   m_boot;
   bit   m_pend, m_src, m_take, m_rst, m_busy;
   logic [7:0] m_vec;

   int_sequencer #(
      .RESET_CYCLES(RESET_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .nmi     (nmi),
      .irq     (irq),
      .I       (I),
      .sync    (sync),
      .vec_ack (vec_ack),
      .core_rst(core_rst),
      .take_int(take_int),
      .vec_lo  (vec_lo),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   // Applies the inputs present at a rising edge to the model. nh/ih hold the
   // raw input sampled at past edges (index 0 = previous edge), so the
   // synchronised line is the sample SYNC_STAGES-1 entries back.
   function automatic void model_step();
      bit rise, irq_seen, clr, old_pend, old_take;
      if (reset) begin
         m_phase = PH_HOLD;
         m_boot  = 0;
         m_pend  = 1'b0;
         m_src   = 1'b0;
         m_take  = 1'b0;
         m_vec   = 8'hFC;
         for (int k = 0; k <= SYNC_STAGES; k++) begin
            nh[k] = 1'b0;
            ih[k] = 1'b0;
         end
      end else begin
         rise     = nh[SYNC_STAGES-1] & ~nh[SYNC_STAGES];
         irq_seen = ih[SYNC_STAGES-1];
         old_pend = m_pend;
         old_take = m_take;
         clr      = (m_phase == PH_SVC) && vec_ack && m_src;
         m_take   = 1'b0;
         if (m_phase == PH_HOLD) begin
            m_boot++;
            if (m_boot >= RESET_CYCLES) begin
               m_phase = PH_RVEC;
               m_vec   = 8'hFC;
            end
         end else if (m_phase == PH_RVEC) begin
            if (vec_ack) m_phase = PH_IDLE;
         end else if (m_phase == PH_IDLE) begin
            if (sync && old_take) begin
               m_src   = old_pend;
               m_vec   = old_pend ? 8'hFA : 8'hFE;
               m_phase = PH_SVC;
            end else begin
               m_take = old_pend | (irq_seen & ~I);
            end
         end else begin
            if (vec_ack) m_phase = PH_IDLE;
         end
         m_pend = rise | (old_pend & ~clr);
         for (int k = SYNC_STAGES; k > 0; k--) begin
            nh[k] = nh[k-1];
            ih[k] = ih[k-1];
         end
         nh[0] = nmi;
         ih[0] = irq;
      end
      m_rst  = (m_phase == PH_HOLD);
      m_busy = (m_phase == PH_RVEC) || (m_phase == PH_SVC);
   endfunction

   // One clock: the model sees the same inputs as the DUT at the rising
   // edge; inputs change and outputs are read at the falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      int cnt;
      reset = 1'b1;
      repeat (3) tick();
      n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL rst_core_rst got %b want 1", core_rst); end
      n_checks++; if (take_int !== 1'b0) begin n_fail++; $display("FAIL rst_take_int got %b want 0", take_int); end
      n_checks++; if (vec_lo !== 8'hFC) begin n_fail++; $display("FAIL rst_vec_lo got %h want fc", vec_lo); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
      reset = 1'b0;
      cnt = 0;
      while (core_rst === 1'b1 && cnt < 20) begin
         cnt++;
         tick();
      end
      n_checks++; if (cnt != RESET_CYCLES) begin n_fail++; $display("FAIL rst_hold_len got %0d want %0d", cnt, RESET_CYCLES); end
      n_checks++; if (busy !== 1'b1 || vec_lo !== 8'hFC || take_int !== 1'b0) begin
         n_fail++; $display("FAIL rstvec_outs got busy=%b vec=%h take=%b want busy=1 vec=fc take=0", busy, vec_lo, take_int);
      end
      vec_ack = 1'b1;
      tick();
      vec_ack = 1'b0;
      n_checks++; if (busy !== 1'b0 || core_rst !== 1'b0 || vec_lo !== 8'hFC) begin
         n_fail++; $display("FAIL rstvec_ack got busy=%b rst=%b vec=%h want 0 0 fc", busy, core_rst, vec_lo);
      end
   endtask

   task automatic test_irq();
      int t;
      I   = 1'b0;
      irq = 1'b1;
      t = 0;
      while (take_int !== 1'b1 && t < 10) begin
         tick();
         t++;
      end
      n_checks++; if (t != SYNC_STAGES + 1) begin n_fail++; $display("FAIL irq_latency got %0d want %0d", t, SYNC_STAGES + 1); end
      sync = 1'b1;
      tick();
      sync = 1'b0;
      n_checks++; if (vec_lo !== 8'hFE || busy !== 1'b1 || take_int !== 1'b0) begin
         n_fail++; $display("FAIL irq_entry got vec=%h busy=%b take=%b want fe 1 0", vec_lo, busy, take_int);
      end
      vec_ack = 1'b1;
      tick();
      vec_ack = 1'b0;
      n_checks++; if (busy !== 1'b0 || take_int !== 1'b0) begin
         n_fail++; $display("FAIL irq_return got busy=%b take=%b want 0 0", busy, take_int);
      end
      tick();
      n_checks++; if (take_int !== 1'b1) begin n_fail++; $display("FAIL irq_rerequest got %b want 1", take_int); end
      // drop the level before the core reaches sync: request withdrawn
      irq = 1'b0;
      t = 0;
      while (take_int !== 1'b0 && t < 10) begin
         tick();
         t++;
      end
      n_checks++; if (t != SYNC_STAGES + 1) begin n_fail++; $display("FAIL irq_drop_latency got %0d want %0d", t, SYNC_STAGES + 1); end
      sync = 1'b1;
      tick();
      sync = 1'b0;
      n_checks++; if (busy !== 1'b0 || vec_lo !== 8'hFE) begin
         n_fail++; $display("FAIL irq_dropped_no_entry got busy=%b vec=%h want 0 fe", busy, vec_lo);
      end
   endtask

   task automatic test_nmi();
      int t;
      irq = 1'b1;
      I   = 1'b1;
      repeat (4) tick();
      n_checks++; if (take_int !== 1'b0) begin n_fail++; $display("FAIL irq_masked got %b want 0", take_int); end
      nmi = 1'b1;
      tick();
      nmi = 1'b0;
      t = 0;
      while (take_int !== 1'b1 && t < 10) begin tick(); t++; end
      n_checks++; if (take_int !== 1'b1) begin n_fail++; $display("FAIL nmi_request got %b want 1", take_int); end
      sync = 1'b1;
      tick();
      sync = 1'b0;
      n_checks++; if (vec_lo !== 8'hFA || busy !== 1'b1) begin
         n_fail++; $display("FAIL nmi_entry got vec=%h busy=%b want fa 1", vec_lo, busy);
      end
      vec_ack = 1'b1;
      tick();
      vec_ack = 1'b0;
      repeat (3) tick();
      n_checks++; if (take_int !== 1'b0) begin n_fail++; $display("FAIL nmi_cleared got %b want 0", take_int); end
      // held high: exactly one entry
      nmi = 1'b1;
      t = 0;
      while (take_int !== 1'b1 && t < 10) begin tick(); t++; end
      n_checks++; if (take_int !== 1'b1) begin n_fail++; $display("FAIL nmi_held_first got %b want 1", take_int); end
      sync = 1'b1;
      tick();
      sync = 1'b0;
      vec_ack = 1'b1;
      tick();
      vec_ack = 1'b0;
      t = 0;
      repeat (8) begin
         tick();
         if (take_int !== 1'b0) t++;
      end
      n_checks++; if (t != 0 || vec_lo !== 8'hFA) begin
         n_fail++; $display("FAIL nmi_held_once got take_cycles=%0d vec=%h want 0 fa", t, vec_lo);
      end
      nmi = 1'b0;
      irq = 1'b0;
      I   = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_priority();
      int t;
      nmi = 1'b1;
      irq = 1'b1;
      t = 0;
      while (take_int !== 1'b1 && t < 10) begin tick(); t++; end
      sync = 1'b1;
      tick();
      sync = 1'b0;
      n_checks++; if (vec_lo !== 8'hFA) begin n_fail++; $display("FAIL prio_first got %h want fa", vec_lo); end
      vec_ack = 1'b1;
      tick();
      vec_ack = 1'b0;
      tick();
      n_checks++; if (take_int !== 1'b1) begin n_fail++; $display("FAIL prio_irq_request got %b want 1", take_int); end
      sync = 1'b1;
      tick();
      sync = 1'b0;
      n_checks++; if (vec_lo !== 8'hFE || busy !== 1'b1) begin
         n_fail++; $display("FAIL prio_second got vec=%h busy=%b want fe 1", vec_lo, busy);
      end
      vec_ack = 1'b1;
      tick();
      vec_ack = 1'b0;
      nmi = 1'b0;
      irq = 1'b0;
      repeat (5) tick();
      n_checks++; if (take_int !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL prio_settle got take=%b busy=%b want 0 0", take_int, busy);
      end
   endtask

   task automatic test_nmi_on_ack();
      int t;
      nmi = 1'b1;
      tick();
      nmi = 1'b0;
      t = 0;
      while (take_int !== 1'b1 && t < 10) begin tick(); t++; end
      sync = 1'b1;
      tick();
      sync = 1'b0;
      n_checks++; if (vec_lo !== 8'hFA || busy !== 1'b1) begin
         n_fail++; $display("FAIL ack_edge_entry got vec=%h busy=%b want fa 1", vec_lo, busy);
      end
      // the edge is detected SYNC_STAGES edges after the line rises
      nmi = 1'b1;
      repeat (SYNC_STAGES) tick();
      vec_ack = 1'b1;
      tick();
      vec_ack = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ack_edge_return got %b want 0", busy); end
      tick();
      n_checks++; if (take_int !== 1'b1) begin n_fail++; $display("FAIL ack_edge_pending got %b want 1", take_int); end
      sync = 1'b1;
      tick();
      sync = 1'b0;
      n_checks++; if (vec_lo !== 8'hFA || busy !== 1'b1) begin
         n_fail++; $display("FAIL ack_edge_second got vec=%h busy=%b want fa 1", vec_lo, busy);
      end
      vec_ack = 1'b1;
      tick();
      vec_ack = 1'b0;
      nmi = 1'b0;
      repeat (4) tick();
      n_checks++; if (take_int !== 1'b0) begin n_fail++; $display("FAIL ack_edge_settle got %b want 0", take_int); end
   endtask

   task automatic test_reset_in_service();
      int t;
      irq = 1'b1;
      t = 0;
      while (take_int !== 1'b1 && t < 10) begin tick(); t++; end
      sync = 1'b1;
      tick();
      sync = 1'b0;
      irq = 1'b0;
      n_checks++; if (busy !== 1'b1 || vec_lo !== 8'hFE) begin
         n_fail++; $display("FAIL svc_rst_entry got busy=%b vec=%h want 1 fe", busy, vec_lo);
      end
      // leave an NMI pending, then reset must discard it
      nmi = 1'b1;
      tick();
      nmi = 1'b0;
      repeat (SYNC_STAGES + 1) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++; if (core_rst !== 1'b1 || take_int !== 1'b0 || vec_lo !== 8'hFC || busy !== 1'b0) begin
         n_fail++; $display("FAIL svc_rst_outs got rst=%b take=%b vec=%h busy=%b want 1 0 fc 0", core_rst, take_int, vec_lo, busy);
      end
      t = 0;
      while (busy !== 1'b1 && t < 20) begin tick(); t++; end
      vec_ack = 1'b1;
      tick();
      vec_ack = 1'b0;
      repeat (4) tick();
      n_checks++; if (take_int !== 1'b0 || core_rst !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL svc_rst_pend_cleared got take=%b rst=%b busy=%b want 0 0 0", take_int, core_rst, busy);
      end
   endtask

   task automatic test_random();
      logic [10:0] got, want;
      for (int c = 0; c < 800; c++) begin
         reset   = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 9) == 0) nmi = ~nmi;
         if ($urandom_range(0, 7) == 0) irq = ~irq;
         if ($urandom_range(0, 15) == 0) I = ~I;
         sync    = ($urandom_range(0, 2) == 0);
         vec_ack = ($urandom_range(0, 2) == 0);
         tick();
         got  = {core_rst, take_int, busy, vec_lo};
         want = {m_rst, m_take, m_busy, m_vec};
         n_checks++; if (got !== want) begin
            n_fail++; $display("FAIL random_c%0d got rst/take/busy/vec=%h want %h", c, got, want);
         end
      end
      reset = 1'b0; nmi = 1'b0; irq = 1'b0; I = 1'b0; sync = 1'b0; vec_ack = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_irq();
      test_nmi();
      test_priority();
      test_nmi_on_ack();
      test_reset_in_service();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
